stage4_mem_access_unit: RTL
===========================

# stage4_mem_access_unit

Memory-access engine for the MEM (stage 4) of the RV32IM pipeline. Takes the stage-4 load/store request, lines up bytes and halfwords on a 32-bit word-addressed data-memory bus, and handles the busywait handshake. Holds the pipeline with STALL until the access completes. Keeps the last loaded value so a load→store pair on the same register is forwarded without a second read; the stage-4 forward unit selects this path with FORWARD_SEL.

## Interface
- MAX_WAIT, 255: largest number of consecutive MEM_BUSYWAIT-high cycles before the access is aborted.
- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- STAGE4_MEM_READ  in  1  load in stage 4
- STAGE4_MEM_WRITE  in  1  store in stage 4
- FUNCT3  in  3  access size and sign (RV32 load/store encoding)
- ADDRESS  in  32  byte address from the ALU
- STORE_DATA  in  32  rs2 value of the store
- FORWARD_SEL  in  1  1 = use LAST_LOAD as store data
- MEM_READDATA  in  32  word returned by data memory
- MEM_BUSYWAIT  in  1  1 = memory not yet done
- MEM_READ  out  1  bus read request
- MEM_WRITE  out  1  bus write request
- MEM_ADDRESS  out  32  {ADDRESS[31:2], 2'b00}
- MEM_WRITEDATA  out  32  store data shifted into the correct lanes
- MEM_BYTEMASK  out  4  active byte lanes for the write
- LOAD_DATA  out  32  extended load result
- STALL  out  1  freeze stages 1–4
- BUS_ERROR  out  1  one-cycle pulse on timeout

## Operation
- FSM has three states: IDLE, ACCESS, DONE.
  - IDLE: when READ or WRITE is requested (not both), capture the address, mask and write data, then go to ACCESS.
  - ACCESS: MEM_READ or MEM_WRITE is held high. When MEM_BUSYWAIT is sampled low, capture the read word and go to DONE. Otherwise increment the wait counter.
  - If the wait counter reaches MAX_WAIT, drop the request, pulse BUS_ERROR, force LOAD_DATA to 0 and go to DONE.
  - DONE: always go to IDLE. The request inputs are still asserted in DONE and must not restart an access.
- If STAGE4_MEM_READ and STAGE4_MEM_WRITE are both high, the access is treated as a write.
- Loads, with lane taken from ADDRESS[1:0]:
  - LB (000) / LBU (100): byte sign- or zero-extended.
  - LH (001) / LHU (101): halfword from ADDRESS[1], sign- or zero-extended.
  - LW (010): full word.
  - Other FUNCT3 values return the raw word.
- Stores:
  - SB: data byte replicated to all four lanes, mask 0001<<ADDRESS[1:0].
  - SH: mask 0011 or 1100 selected by ADDRESS[1].
  - SW: mask 1111.
- LAST_LOAD register is updated with the extended result at the end of every load's DONE cycle.
- Store data source = FORWARD_SEL ? LAST_LOAD : STORE_DATA, chosen before lane shifting.
- Wait counter is ceil(log2(MAX_WAIT+1)) bits and is cleared on entry to ACCESS.

## Timing
- STALL is combinational: high in IDLE when a request is present, and in ACCESS. Low in DONE, so the pipeline advances at the end of DONE.
- MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA and MEM_BYTEMASK are registered and change only on state entry.
- Minimum latency with zero-wait memory:
  - request seen in cycle 0, ACCESS in cycle 1, DONE in cycle 2;
  - STALL high for 2 cycles;
  - LOAD_DATA valid in DONE and held until the next load completes.
- Back-to-back accesses: the next instruction's request is seen in the IDLE cycle after DONE. No bubble is added beyond that.
- Values held in reset:
  - state = IDLE; wait counter = 0;
  - MEM_READ = MEM_WRITE = 0; MEM_ADDRESS = MEM_WRITEDATA = 0; MEM_BYTEMASK = 0;
  - LOAD_DATA = LAST_LOAD = 0; BUS_ERROR = 0;
  - STALL = 0 while RESET is high.
- Reset mid-access abandons the bus cycle at once. The bus requests drop asynchronously.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - LH, LHU and SH with ADDRESS[0]=1, or LW and SW with ADDRESS[1:0]≠0, are trapped.
  - A trapped access skips ACCESS and goes IDLE→DONE with no bus request.
  - MISALIGN_EXCEPTION (an extra output port, 1 bit, reset 0) pulses high in DONE.
  - LOAD_DATA is unchanged and memory is not written.
- MEM_MISALIGN_TRAP_EN undefined:
  - The MISALIGN_EXCEPTION port is absent.
  - Misaligned accesses use the lane rules above, so the low address bits beyond the access size are ignored.

## Structure
- Shared package rv32_mem_pkg holds:
  - FUNCT3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - the FSM state encoding.
- One combinational sub-module, load_extend_unit: takes the captured word, ADDRESS[1:0] and FUNCT3, and returns the extended LOAD_DATA.

## Test plan
- LW at 0x100, MEM_READDATA=0xDEADBEEF, busywait low in the first ACCESS cycle → STALL high 2 cycles, LOAD_DATA=0xDEADBEEF in DONE.
- LB at 0x103 with word 0x80FF_0000 → LOAD_DATA=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x202 with STORE_DATA=0x1234ABCD → MEM_BYTEMASK=1100, MEM_WRITEDATA[31:16]=0xABCD, MEM_ADDRESS=0x200.
- LW returns 0xCAFEF00D, then SW with FORWARD_SEL=1 and STORE_DATA=0 → MEM_WRITEDATA=0xCAFEF00D.
- MEM_BUSYWAIT held high with MAX_WAIT=4 → BUS_ERROR pulses after 4 wait cycles, LOAD_DATA=0, back in IDLE.
- RESET raised in the second ACCESS cycle → MEM_READ drops immediately, STALL=0, LAST_LOAD=0. Under MEM_MISALIGN_TRAP_EN, LW at 0x101 → MISALIGN_EXCEPTION pulse and no MEM_READ.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared RV32 load/store FUNCT3 codes and the stage-4 access FSM encoding.
// Used by stage4_mem_access_unit and load_extend_unit.
package rv32_mem_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/stage4_mem_access_unit_load_extend.sv
// Picks the addressed byte/halfword out of a bus word and extends it
// according to the RV32 load FUNCT3 encoding.
module load_extend_unit
  import rv32_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    unique case (lane_i)
      2'd0:    byte_v = word_i[7:0];
      2'd1:    byte_v = word_i[15:8];
      2'd2:    byte_v = word_i[23:16];
      default: byte_v = word_i[31:24];
    endcase
    half_v = lane_i[1] ? word_i[31:16] : word_i[15:0];
    unique case (funct3_i)
      LB:      data_o = {{24{byte_v[7]}}, byte_v};
      LH:      data_o = {{16{half_v[15]}}, half_v};
      LBU:     data_o = {24'h0, byte_v};
      LHU:     data_o = {16'h0, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/stage4_mem_access_unit.sv
// Stage-4 load/store engine: lane alignment, busywait handshake, timeout.
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module stage4_mem_access_unit
  import rv32_mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STAGE4_MEM_READ,
  input  logic        STAGE4_MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] STORE_DATA,
  input  logic        FORWARD_SEL,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTEMASK,
  output logic [31:0] LOAD_DATA,
  output logic        STALL,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        BUS_ERROR,
  output logic        MISALIGN_EXCEPTION
`else
  output logic        BUS_ERROR
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;
  logic [1:0]    lane_q, lane_d;
  logic [2:0]    f3_q, f3_d;
  logic          is_load_q, is_load_d;
  logic [31:0]   load_q, load_d;
  logic [31:0]   last_q, last_d;
  logic          err_q, err_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic          mis_q, mis_d;
`endif

  logic          req, is_wr, trap, timeout;
  logic [WW-1:0] wait_inc;
  logic [31:0]   src, st_data, ext_data;
  logic [3:0]    st_mask;

  assign req      = STAGE4_MEM_READ | STAGE4_MEM_WRITE;
  assign is_wr    = STAGE4_MEM_WRITE;
  assign src      = FORWARD_SEL ? last_q : STORE_DATA;
  assign wait_inc = wait_q + WW'(1);
  assign timeout  = MEM_BUSYWAIT && (wait_inc == WW'(MAX_WAIT));

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (FUNCT3[1:0] == 2'b01 && ADDRESS[0]) ||
                (FUNCT3 == LW && ADDRESS[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  // Data is replicated across lanes; the mask selects the live ones.
  always_comb begin
    unique case (FUNCT3[1:0])
      2'b00: begin
        st_data = {4{src[7:0]}};
        st_mask = 4'b0001 << ADDRESS[1:0];
      end
      2'b01: begin
        st_data = {2{src[15:0]}};
        st_mask = ADDRESS[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = src;
        st_mask = 4'b1111;
      end
    endcase
  end

  load_extend_unit u_ext (
    .word_i   (MEM_READDATA),
    .lane_i   (lane_q),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = trap ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (!MEM_BUSYWAIT || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_d    = wait_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    lane_d    = lane_q;
    f3_d      = f3_q;
    is_load_d = is_load_q;
    load_d    = load_q;
    last_d    = last_q;
    err_d     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d    = {ADDRESS[31:2], 2'b00};
          lane_d    = ADDRESS[1:0];
          f3_d      = FUNCT3;
          wdata_d   = st_data;
          mask_d    = is_wr ? st_mask : 4'b0000;
          wait_d    = '0;
          is_load_d = !is_wr && !trap;
          rd_d      = !is_wr && !trap;
          wr_d      = is_wr && !trap;
`ifdef MEM_MISALIGN_TRAP_EN
          mis_d     = trap;
`endif
        end
      end
      ST_ACCESS: begin
        if (!MEM_BUSYWAIT) begin
          rd_d = 1'b0;
          wr_d = 1'b0;
          if (is_load_q) load_d = ext_data;
        end else if (timeout) begin
          rd_d   = 1'b0;
          wr_d   = 1'b0;
          err_d  = 1'b1;
          load_d = '0;
        end else begin
          wait_d = wait_inc;
        end
      end
      ST_DONE: begin
        if (is_load_q) last_d = load_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wait_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      lane_q    <= '0;
      f3_q      <= '0;
      is_load_q <= 1'b0;
      load_q    <= '0;
      last_q    <= '0;
      err_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      wait_q    <= wait_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      lane_q    <= lane_d;
      f3_q      <= f3_d;
      is_load_q <= is_load_d;
      load_q    <= load_d;
      last_q    <= last_d;
      err_q     <= err_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign STALL = !RESET &&
                 ((state_q == ST_IDLE && req) || state_q == ST_ACCESS);

  assign MEM_READ      = rd_q;
  assign MEM_WRITE     = wr_q;
  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;
  assign MEM_BYTEMASK  = mask_q;
  assign LOAD_DATA     = load_q;
  assign BUS_ERROR     = err_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign MISALIGN_EXCEPTION = mis_q;
`endif

endmodule
